// File: rtl/buffer_pkg.sv
// Shared types and constants for the word-buffer arbiter.
package buffer_pkg;

    localparam int WORD_W     = 64;
    localparam int BYTE_LANES = 8;

    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_WR
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester above the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] last_d;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        grant   = '0;
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((int'(last_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end
        last_d = (advance && found) ? win_idx : last_q;
    end

    // Last winner starts at NUM_REQ-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IdxW'(NUM_REQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin sharing of a 64-bit word buffer; byte writes become read-modify-write.
module buffer_arbiter
    import buffer_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BuffDepth = 256,
    parameter int ByteAddrW = $clog2(BuffDepth),
    parameter int WordAddrW = $clog2(BuffDepth / 8)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [NUM_REQ*ByteAddrW-1:0]   req_addr,
    input  logic [NUM_REQ*64-1:0]          req_wdata,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [63:0]                    resp_rdata,
    output logic                           buf_read_en,
    output logic                           buf_write_en,
    output logic [WordAddrW-1:0]           buf_word_addr,
    output logic [63:0]                    buf_word_in,
    input  logic [63:0]                    buf_word_out
);

    localparam int IdW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LaneW = $clog2(BYTE_LANES);

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant;
    logic                   accept;

    logic                   cmd_valid_q, cmd_valid_d;
    logic                   cmd_write_q, cmd_write_d;
    logic                   cmd_mode_q, cmd_mode_d;
    logic [ByteAddrW-1:0]   cmd_addr_q, cmd_addr_d;
    logic [WORD_W-1:0]      cmd_wdata_q, cmd_wdata_d;
    logic [IdW-1:0]         cmd_id_q, cmd_id_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_byte_q, rsp_byte_d;
    logic [LaneW-1:0]       rsp_lane_q, rsp_lane_d;
    logic [IdW-1:0]         rsp_id_q, rsp_id_d;

    logic                   rd_issue;
    logic                   wr_issue;
    logic [LaneW-1:0]       cmd_lane;
    logic [WORD_W-1:0]      merged_word;
    logic [7:0]             rsp_byte_val;

    // Arbitration only happens in IDLE; reset also holds off any acceptance.
    assign arb_req   = (state_q == IDLE && !rst) ? req_valid : '0;
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        cmd_valid_d = accept;
        cmd_write_d = cmd_write_q;
        cmd_mode_d  = cmd_mode_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_id_d    = cmd_id_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                cmd_write_d = req_write[i];
                cmd_mode_d  = req_mode[i];
                cmd_addr_d  = req_addr[i*ByteAddrW +: ByteAddrW];
                cmd_wdata_d = req_wdata[i*64 +: 64];
                cmd_id_d    = IdW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && cmd_write_d && cmd_mode_d == MODE_BYTE) begin
                    state_d = RMW_RD;
                end
            end
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A byte write sits in the command registers for both RMW cycles.
    always_comb begin
        cmd_lane = cmd_addr_q[LaneW-1:0];
        rd_issue = (state_q == RMW_RD) || (state_q == IDLE && cmd_valid_q && !cmd_write_q);
        wr_issue = (state_q == RMW_WR) || (state_q == IDLE && cmd_valid_q && cmd_write_q);

        merged_word = buf_word_out;
        for (int l = 0; l < BYTE_LANES; l++) begin
            if (cmd_lane == LaneW'(l)) begin
                merged_word[l*8 +: 8] = cmd_wdata_q[7:0];
            end
        end

        buf_read_en   = rd_issue;
        buf_write_en  = wr_issue;
        buf_word_addr = (rd_issue || wr_issue) ? cmd_addr_q[ByteAddrW-1:LaneW] : '0;
        buf_word_in   = '0;
        if (state_q == RMW_WR) begin
            buf_word_in = merged_word;
        end else if (wr_issue) begin
            buf_word_in = cmd_wdata_q;
        end

        rsp_valid_d = (state_q == IDLE) && cmd_valid_q && !cmd_write_q;
        rsp_byte_d  = (cmd_mode_q == MODE_BYTE);
        rsp_lane_d  = cmd_lane;
        rsp_id_d    = cmd_id_q;
    end

    // Read data arrives one cycle after buf_read_en; format it for the owner.
    always_comb begin
        rsp_byte_val = '0;
        for (int l = 0; l < BYTE_LANES; l++) begin
            if (rsp_lane_q == LaneW'(l)) begin
                rsp_byte_val = buf_word_out[l*8 +: 8];
            end
        end

        resp_valid = '0;
        resp_rdata = '0;
        if (rsp_valid_q) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                resp_valid[i] = (rsp_id_q == IdW'(i));
            end
            resp_rdata = rsp_byte_q ? {{(WORD_W-8){1'b0}}, rsp_byte_val} : buf_word_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        cmd_write_q <= cmd_write_d;
        cmd_mode_q  <= cmd_mode_d;
        cmd_addr_q  <= cmd_addr_d;
        cmd_wdata_q <= cmd_wdata_d;
        cmd_id_q    <= cmd_id_d;
        rsp_byte_q  <= rsp_byte_d;
        rsp_lane_q  <= rsp_lane_d;
        rsp_id_q    <= rsp_id_d;
    end

endmodule

// File: tb/tb_buffer_arbiter.sv
// Bench for buffer_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_buffer_arbiter;

    localparam int NUM_REQ = 3;
    localparam int BD      = 256;
    localparam int ABW     = 8;
    localparam int WAW     = 5;
    localparam int NW      = BD / 8;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid, req_ready, req_write, req_mode, resp_valid;
    logic [NUM_REQ*ABW-1:0] req_addr;
    logic [NUM_REQ*64-1:0]  req_wdata;
    logic [63:0]            resp_rdata;
    logic                   buf_read_en, buf_write_en;
    logic [WAW-1:0]         buf_word_addr;
    logic [63:0]            buf_word_in, buf_word_out;

    logic                   t_valid [NUM_REQ];
    logic                   t_write [NUM_REQ];
    logic                   t_mode  [NUM_REQ];
    logic [ABW-1:0]         t_addr  [NUM_REQ];
    logic [63:0]            t_wdata [NUM_REQ];

    logic [63:0]            bmem    [NW];
    logic [63:0]            ref_mem [NW];
    logic                   model_on;
    int                     n_chk, n_pass;

    typedef struct {
        bit          rd;
        bit          wr;
        bit          rmw;
        bit          byte_op;
        int          addr;
        int          lane;
        int          id;
        logic [63:0] wword;
        logic [7:0]  wb;
        bit          rsp;
        int          rsp_id;
        logic [63:0] rsp_data;
    } ev_t;

    ev_t sched [3];
    int  m_busy, m_last;

    buffer_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .BuffDepth (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_mode      (req_mode),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .buf_read_en   (buf_read_en),
        .buf_write_en  (buf_write_en),
        .buf_word_addr (buf_word_addr),
        .buf_word_in   (buf_word_in),
        .buf_word_out  (buf_word_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]              = t_valid[i];
            req_write[i]              = t_write[i];
            req_mode[i]               = t_mode[i];
            req_addr[i*ABW +: ABW]    = t_addr[i];
            req_wdata[i*64 +: 64]     = t_wdata[i];
        end
    end

    function automatic logic [63:0] pat(int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101_0101_0101);
    endfunction

    function automatic logic [63:0] put_byte(logic [63:0] w, int lane, logic [7:0] b);
        logic [63:0] mask;
        mask = 64'hFF << (lane * 8);
        return (w & ~mask) | (64'(b) << (lane * 8));
    endfunction

    function automatic logic [63:0] get_byte(logic [63:0] w, int lane);
        return (w >> (lane * 8)) & 64'hFF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // The buffer itself: synchronous word memory, read data valid the next cycle.
    initial begin : buffer_model
        for (int i = 0; i < NW; i++) bmem[i] = pat(i);
        buf_word_out <= '0;
        forever begin
            @(posedge clk);
            if (buf_read_en) buf_word_out <= bmem[buf_word_addr];
            if (buf_write_en) bmem[buf_word_addr] = buf_word_in;
        end
    end

    // Transaction model: an acceptance schedules buffer activity 1-2 cycles ahead.
    initial begin : model
        logic [NUM_REQ-1:0] exp_ready, exp_rv;
        logic [63:0]        exp_in;
        int                 g, idx, a;
        for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
        for (int i = 0; i < 3; i++) sched[i] = '{default: '0};
        m_busy = 0;
        m_last = NUM_REQ - 1;
        forever begin
            @(negedge clk);
            if (model_on) begin
                g = -1;
                if (!rst && m_busy == 0) begin
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        idx = (m_last + k) % NUM_REQ;
                        if (g < 0 && t_valid[idx]) g = idx;
                    end
                end
                exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
                exp_in    = '0;
                if (sched[0].wr)
                    exp_in = sched[0].byte_op ?
                             put_byte(ref_mem[sched[0].addr], sched[0].lane, sched[0].wb) :
                             sched[0].wword;
                exp_rv = sched[0].rsp ? (NUM_REQ'(1) << sched[0].rsp_id) : '0;

                chk("req_ready", req_ready, exp_ready);
                chk("rd_wr_overlap", buf_read_en & buf_write_en, 0);
                chk("buf_read_en", buf_read_en, sched[0].rd);
                chk("buf_write_en", buf_write_en, sched[0].wr);
                if (sched[0].rd || sched[0].wr) chk("buf_word_addr", buf_word_addr, sched[0].addr);
                if (sched[0].wr) chk("buf_word_in", buf_word_in, exp_in);
                chk("resp_valid", resp_valid, exp_rv);
                if (sched[0].rsp) chk("resp_rdata", resp_rdata, sched[0].rsp_data);

                if (sched[0].wr) ref_mem[sched[0].addr] = exp_in;
                if (rst) begin
                    for (int i = 0; i < 3; i++) sched[i] = '{default: '0};
                    m_busy = 0;
                    m_last = NUM_REQ - 1;
                end else begin
                    if (sched[0].rd && !sched[0].rmw) begin
                        sched[1].rsp      = 1'b1;
                        sched[1].rsp_id   = sched[0].id;
                        sched[1].rsp_data = sched[0].byte_op ?
                                            get_byte(ref_mem[sched[0].addr], sched[0].lane) :
                                            ref_mem[sched[0].addr];
                    end
                    if (m_busy > 0) m_busy--;
                    if (g >= 0) begin
                        m_last = g;
                        a = int'(t_addr[g]);
                        if (!t_write[g]) begin
                            sched[1].rd      = 1'b1;
                            sched[1].addr    = a / 8;
                            sched[1].lane    = a % 8;
                            sched[1].byte_op = (t_mode[g] == 1'b0);
                            sched[1].id      = g;
                        end else if (t_mode[g]) begin
                            sched[1].wr      = 1'b1;
                            sched[1].addr    = a / 8;
                            sched[1].byte_op = 1'b0;
                            sched[1].wword   = t_wdata[g];
                        end else begin
                            sched[1].rd      = 1'b1;
                            sched[1].rmw     = 1'b1;
                            sched[1].addr    = a / 8;
                            sched[2].wr      = 1'b1;
                            sched[2].addr    = a / 8;
                            sched[2].byte_op = 1'b1;
                            sched[2].lane    = a % 8;
                            sched[2].wb      = t_wdata[g][7:0];
                            m_busy           = 2;
                        end
                    end
                    sched[0] = sched[1];
                    sched[1] = sched[2];
                    sched[2] = '{default: '0};
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input int id, input bit w, input bit md, input int a,
                         input logic [63:0] d, output int n);
        t_write[id] = w;
        t_mode[id]  = md;
        t_addr[id]  = ABW'(a);
        t_wdata[id] = d;
        t_valid[id] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((req_ready >> id) & 1) == 0 && n < 40);
        chk("accepted", (req_ready >> id) & 1, 1);
        @(posedge clk);
        #1;
        t_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(input int id, output logic [63:0] d, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((resp_valid >> id) & 1) == 0 && n < 20);
        chk("resp_seen", (resp_valid >> id) & 1, 1);
        d = resp_rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          n;
        logic [63:0] d;
        n_chk    = 0;
        n_pass   = 0;
        model_on = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_valid[i] = 1'b0; t_write[i] = 1'b0; t_mode[i] = 1'b0;
            t_addr[i]  = '0;   t_wdata[i] = '0;
        end
        @(posedge clk); #1;
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_buf_en", {buf_read_en, buf_write_en}, 0);
        chk("rst_buf_addr", buf_word_addr, 0);
        chk("rst_buf_in", buf_word_in, 0);
        @(posedge clk); #1;

        // Word write then word read of the same word.
        issue(0, 1, 1, 'h10, 64'h1122334455667788, n);
        issue(0, 0, 1, 'h10, 64'h0, n);
        wait_resp(0, d, n);
        chk("rd_latency", n, 2);
        chk("word_rd_data", d, 64'h1122334455667788);

        // Byte write merges into an all-ones word; the follower stalls through the RMW.
        issue(0, 1, 1, 'h10, 64'hFFFF_FFFF_FFFF_FFFF, n);
        issue(1, 1, 0, 'h13, 64'h5A, n);
        issue(0, 0, 1, 'h10, 64'h0, n);
        chk("rmw_stall", n, 3);
        wait_resp(0, d, n);
        chk("rmw_merge_data", d, 64'hFFFF_FFFF_5AFF_FFFF);

        // Byte read of lane 6.
        issue(0, 1, 1, 'h10, 64'h0807060504030201, n);
        issue(1, 0, 0, 'h16, 64'h0, n);
        wait_resp(1, d, n);
        chk("byte_rd_data", d, 64'h07);

        // Two requesters reading every cycle alternate from requester 0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        t_write[0] = 1'b0; t_mode[0] = 1'b1; t_addr[0] = 8'h08;
        t_write[1] = 1'b0; t_mode[1] = 1'b1; t_addr[1] = 8'h18;
        t_valid[0] = 1'b1; t_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("grant_seq", req_ready, (i % 2 == 0) ? 1 : 2);
        end
        @(posedge clk); #1;
        t_valid[0] = 1'b0; t_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset during RMW_RD drops the write.
        issue(0, 1, 1, 'h20, 64'hA5A5_A5A5_A5A5_A5A5, n);
        issue(1, 1, 0, 'h21, 64'h00, n);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_buf_en", {buf_read_en, buf_write_en}, 0);
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_buf_in", buf_word_in, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem_word", bmem[4], 64'hA5A5_A5A5_A5A5_A5A5);

        // Read immediately followed by a byte write to the same word.
        issue(0, 0, 1, 'h20, 64'h0, n);
        issue(1, 1, 0, 'h22, 64'h3C, n);
        issue(0, 0, 1, 'h20, 64'h0, n);
        wait_resp(0, d, n);
        chk("rd_then_rmw_data", d, 64'hA5A5_A5A5_A53C_A5A5);

        // Random traffic, including occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                t_valid[i] = 1'($urandom_range(0, 1));
                t_write[i] = 1'($urandom_range(0, 1));
                t_mode[i]  = 1'($urandom_range(0, 1));
                t_addr[i]  = ABW'($urandom_range(0, 47));
                t_wdata[i] = {$urandom(), $urandom()};
            end
            rst = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) t_valid[i] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < NW; i++) chk("final_mem", bmem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/buffer_arbiter.md
Name: buffer_arbiter

Overview:
- Shares one 64-bit-word buffer (buffer_64bit, BuffDepth bytes) between NUM_REQ requesters using round-robin arbitration.
- Each requester issues byte or word reads/writes over a valid/ready handshake.
- Byte writes are done as read-modify-write, so the other 7 bytes of the word are preserved.
- Sits between the buffer and its clients (loader, compute engine). The buffer's own byte ports are tied off; all buffer traffic is word-mode.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BuffDepth, 256, buffer size in bytes (power of 2, >= 8)
ByteAddrW, $clog2(BuffDepth), byte address width
WordAddrW, $clog2(BuffDepth/8), word address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  request valid, one bit per requester
req_ready  output  NUM_REQ  request accepted this cycle when valid&ready
req_write  input  NUM_REQ  1 = write, 0 = read
req_mode  input  NUM_REQ  0 = byte, 1 = word
req_addr  input  NUM_REQ*ByteAddrW  byte address, requester i at [i*ByteAddrW +: ByteAddrW]
req_wdata  input  NUM_REQ*64  write data, requester i at [i*64 +: 64]; byte writes use bits [7:0]
resp_valid  output  NUM_REQ  one-cycle read-data strobe to the owning requester
resp_rdata  output  64  read data, shared by all requesters
buf_read_en  output  1  to buffer read_en
buf_write_en  output  1  to buffer write_en
buf_word_addr  output  WordAddrW  to buffer word_addr
buf_word_in  output  64  to buffer word_in
buf_word_out  input  64  from buffer word_out, valid the cycle after buf_read_en

Behaviour:
- Reset values:
  - All outputs 0 (req_ready, resp_valid, buf_* enables, address, data).
  - FSM goes to IDLE.
  - Round-robin pointer is set so requester 0 has top priority.
  - Any in-flight read or RMW is dropped with no resp_valid.
- FSM states: IDLE, RMW_RD, RMW_WR.
- Arbitration (IDLE only):
  - Grant the first valid requester searching upward from (last_grant+1) mod NUM_REQ.
  - req_ready is one-hot to the granted requester; all-zero in RMW_RD and RMW_WR.
  - Pointer updates only on acceptance.
- Command stage: an accepted request in cycle T is registered and drives the buffer in T+1.
  - buf_read_en and buf_write_en are never both 1.
  - buf_word_addr = addr[ByteAddrW-1:3]. addr[2:0] is ignored for word ops and is the lane k for byte ops.
- Word write accepted in T: buf_write_en=1 in T+1 with buf_word_in=wdata. Stays in IDLE, so back-to-back accepts are allowed.
- Read (byte or word) accepted in T:
  - buf_read_en=1 in T+1.
  - resp_valid[id]=1 in T+2, so latency is 2 cycles.
  - Word read: resp_rdata = buf_word_out.
  - Byte read: resp_rdata = {56'b0, buf_word_out[8k+7:8k]}.
  - Reads pipeline at 1 per cycle.
- Byte write accepted in T (IDLE -> RMW_RD):
  - T+1 (RMW_RD): buf_read_en=1.
  - T+2 (RMW_WR): buf_write_en=1; buf_word_in = buf_word_out with lane k replaced by wdata[7:0].
  - T+3: back to IDLE, arbitration resumes.
  - No resp_valid for writes.
- Read issued in T-1 with RMW accepted in T: its response appears in T+1 as normal. buf_word_out is consumed for the merge only in RMW_WR.
- Ordering: strictly in acceptance order. A read accepted after a write to the same word returns the new data, because the buffer is written at the end of the write's command cycle.
- No response backpressure: requesters must take resp_valid when it is asserted.
- Only the granted requester's fields are sampled; other requesters' inputs are don't-care.
- rst asserted mid-RMW: return to IDLE, no buffer write, no resp_valid the following cycle.

Decomposition:
- Package buffer_pkg holds:
  - constants MODE_BYTE=0, MODE_WORD=1;
  - state enum IDLE/RMW_RD/RMW_WR;
  - WORD_W=64, BYTE_LANES=8.
- One sub-module rr_arbiter:
  - ports NUM_REQ-wide req, grant, and an advance enable;
  - owns the priority pointer.
- Lane select and merge stay inline in buffer_arbiter.

Test Plan:
- Reset, then req0 word write addr 0x10 data 0x1122334455667788, then req0 word read 0x10 -> buf_write_en in T+1, resp_valid[0] at read T+2, resp_rdata=0x1122334455667788.
- Preload word 2 = 0xFFFFFFFFFFFFFFFF; req1 byte write addr 0x13 data 0x5A; word read 0x10 -> ready low 2 cycles, result 0xFFFFFFFF5AFFFFFF.
- Byte read addr 0x16 of word 0x0807060504030201 -> resp_rdata=0x07 at T+2.
- req0 and req1 valid every cycle with reads -> grants alternate 0,1,0,1; resp_valid follows the grant pattern 2 cycles later; one access per cycle.
- Byte write accepted, rst pulsed in RMW_RD -> buf_write_en never asserted, buffer word unchanged, outputs 0 next cycle.
- Read accepted in T, then byte write in T+1 -> read response at T+2 correct, RMW merge uses the RMW's own read data, no buf_read_en/buf_write_en overlap.
